// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
// Package    : serial_add_pkg
// Description: Shared types and helpers for the bit-serial add/subtract
//              sequencer: FSM state encoding, counter-width helper and the
//              legal operand-width check.
// Revision   : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  // Bits needed to count 0..WIDTH-1; CNT_W in the sequencer is derived here.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  function automatic bit width_ok(input int width);
    return (width >= WIDTH_MIN) && (width <= WIDTH_MAX);
  endfunction

endpackage : serial_add_pkg
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module     : full_adder
// Description: Combinational 1-bit full-adder cell.
// Ports      : a, b, cin - addend bits and carry-in
//              sum, cout - sum bit and carry-out
// Revision   : 1.0 - initial release
// ============================================================================
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : serial_adder_ctrl
// Description: Bit-serial add/subtract sequencer. Captures two WIDTH-bit
//              operands on start and pushes one bit pair per clock, LSB
//              first, through a single full-adder cell with a carry flop
//              closing the loop. Reports sum, carry-out and signed overflow
//              with a one-cycle done pulse WIDTH cycles after acceptance.
// Ports      : clk, rst_n          - clock, async active-low reset
//              start, sub, cin     - request, subtract mode, add carry-in
//              a, b                - operands (captured with start)
//              busy, done          - status (ADD/DONE), completion pulse
//              sum, cout, ovf      - result, final carry, signed overflow
// Revision   : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  import serial_add_pkg::*;

  localparam int             CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  if (!width_ok(WIDTH)) begin : g_width_check
    $error("serial_adder_ctrl: WIDTH must be in 2..32");
  end

  state_e             state_q;
  logic [WIDTH-1:0]   opa_q;
  logic [WIDTH-1:0]   opb_q;
  logic [WIDTH-1:0]   sum_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic               ovf_q;
  logic               busy_q;
  logic               done_q;

  logic               w_fa_sum;
  logic               w_fa_cout;

  full_adder u_fa (
    .a    (opa_q[0]),
    .b    (opb_q[0]),
    .cin  (carry_q),
    .sum  (w_fa_sum),
    .cout (w_fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            opa_q   <= a;
            // Subtraction is a + ~b + 1; cin is not used in that mode.
            opb_q   <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            cnt_q   <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_ADD;
          end
        end
        S_ADD: begin
          // Result bits enter at the MSB so after WIDTH shifts bit 0 is LSB.
          sum_q   <= {w_fa_sum, sum_q[WIDTH-1:1]};
          opa_q   <= opa_q >> 1;
          opb_q   <= opb_q >> 1;
          carry_q <= w_fa_cout;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            // carry_q is the carry into the MSB on this last bit.
            ovf_q   <= carry_q ^ w_fa_cout;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = carry_q;
  assign ovf  = ovf_q;

endmodule : serial_adder_ctrl
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : tb_serial_adder_ctrl
// Description: Self-checking bench for serial_adder_ctrl (WIDTH=8). Expected
//              results come from an arithmetic reference model and are queued
//              when an operation is launched, then popped at done.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t sb[$];
  int   n_pass   = 0;
  int   n_total  = 0;
  int   done_cnt = 0;
  int   cyc      = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

  // Reference: two's-complement add with a 9-bit result; overflow when both
  // effective operands share a sign that the result does not.
  function automatic exp_t model(input logic [W-1:0] ia, ib, input logic icin, isub);
    logic [W:0]   full;
    logic [W-1:0] bb;
    logic         ci;
    exp_t         e;
    bb   = isub ? ~ib : ib;
    ci   = isub ? 1'b1 : icin;
    full = {1'b0, ia} + {1'b0, bb} + {{W{1'b0}}, ci};
    e.s  = full[W-1:0];
    e.c  = full[W];
    e.o  = (ia[W-1] == bb[W-1]) && (full[W-1] != ia[W-1]);
    return e;
  endfunction

  // Launches one operation and waits for done (bounded). inject_at pulses
  // start with other operands at that ADD cycle; abort_at asserts reset.
  task automatic run_op(input logic [W-1:0] ia, ib, input logic icin, isub,
                        input int inject_at, input int abort_at,
                        output int lat, output bit seen, output logic busy0);
    @(negedge clk);
    a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
    sb.push_back(model(ia, ib, icin, isub));
    @(posedge clk);
    seen  = 1'b0;
    lat   = -1;
    busy0 = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) busy0 = busy;
      if (k == inject_at) begin
        start = 1'b1; a = 8'h11; b = 8'h11;
      end else begin
        start = 1'b0;
      end
      if (k == abort_at) begin
        rst_n = 1'b0;
        break;
      end
      if (done === 1'b1) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1; sub = 1'b0; a = 8'hA5; b = 8'h5A; cin = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if ({busy, done, sum, cout, ovf} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0})
      $display("FAIL reset_state: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               busy, done, sum, cout, ovf);
    else n_pass++;
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic(input logic [W-1:0] ia, ib, input logic icin, isub, input string nm);
    int   lat;
    bit   seen;
    logic busy0;
    exp_t e;
    run_op(ia, ib, icin, isub, -1, -1, lat, seen, busy0);
    n_total++;
    if (busy0 !== 1'b1) $display("FAIL %s busy_after_accept: got %b want 1", nm, busy0);
    else n_pass++;
    n_total++;
    if (!seen || lat != W) $display("FAIL %s latency: got %0d want %0d", nm, lat, W);
    else n_pass++;
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    n_total++;
    if ({sum, cout, ovf} !== {e.s, e.c, e.o})
      $display("FAIL %s result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
               nm, sum, cout, ovf, e.s, e.c, e.o);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({done, busy} !== 2'b00) $display("FAIL %s done_width: got done=%b busy=%b want 0 0", nm, done, busy);
    else n_pass++;
    n_total++;
    if ({sum, cout, ovf} !== {e.s, e.c, e.o})
      $display("FAIL %s hold: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
               nm, sum, cout, ovf, e.s, e.c, e.o);
    else n_pass++;
  endtask

  task automatic test_ignore_start;
    int   lat;
    bit   seen;
    logic busy0;
    int   d0;
    exp_t e;
    d0 = done_cnt;
    run_op(8'h33, 8'h44, 1'b0, 1'b0, 3, -1, lat, seen, busy0);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    n_total++;
    if (!seen || lat != W) $display("FAIL ignore_start latency: got %0d want %0d", lat, W);
    else n_pass++;
    n_total++;
    if ({sum, cout, ovf} !== {e.s, e.c, e.o})
      $display("FAIL ignore_start result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
               sum, cout, ovf, e.s, e.c, e.o);
    else n_pass++;
    repeat (12) @(negedge clk);
    n_total++;
    if (done_cnt - d0 != 1) $display("FAIL ignore_start done_pulses: got %0d want 1", done_cnt - d0);
    else n_pass++;
    n_total++;
    if ({busy, sum} !== {1'b0, e.s}) $display("FAIL ignore_start idle_after: got busy=%b sum=%h want 0 %h", busy, sum, e.s);
    else n_pass++;
  endtask

  task automatic test_reset_mid_op;
    int   lat;
    bit   seen;
    logic busy0;
    int   d0;
    d0 = done_cnt;
    run_op(8'h7F, 8'h7F, 1'b1, 1'b0, -1, 4, lat, seen, busy0);
    if (sb.size() > 0) void'(sb.pop_back());
    #1;
    n_total++;
    if ({busy, done, sum, cout, ovf} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0})
      $display("FAIL mid_reset outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
               busy, done, sum, cout, ovf);
    else n_pass++;
    start = 1'b1;
    repeat (12) @(negedge clk);
    start = 1'b0;
    n_total++;
    if (done_cnt != d0) $display("FAIL mid_reset no_done: got %0d pulses want 0", done_cnt - d0);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    test_basic(8'hC3, 8'h2D, 1'b1, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] ta[3];
    logic [W-1:0] tb[3];
    logic         ts[3];
    int           tcyc[3];
    int           n;
    exp_t         e;
    ta = '{8'h5A, 8'h80, 8'h01};
    tb = '{8'h3C, 8'h01, 8'h7F};
    ts = '{1'b0, 1'b1, 1'b0};
    n  = 0;
    @(negedge clk);
    a = ta[0]; b = tb[0]; sub = ts[0]; cin = 1'b0; start = 1'b1;
    sb.push_back(model(ta[0], tb[0], 1'b0, ts[0]));
    for (int k = 0; k < 60 && n < 3; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        tcyc[n] = cyc;
        n_total++;
        if ({sum, cout, ovf} !== {e.s, e.c, e.o})
          $display("FAIL b2b op%0d result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                   n, sum, cout, ovf, e.s, e.c, e.o);
        else n_pass++;
        n++;
        if (n < 3) begin
          a = ta[n]; b = tb[n]; sub = ts[n];
          sb.push_back(model(ta[n], tb[n], 1'b0, ts[n]));
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    n_total++;
    if (n != 3) $display("FAIL b2b completed: got %0d ops want 3", n);
    else n_pass++;
    for (int i = 1; i < 3; i++) begin
      if (i < n) begin
        n_total++;
        if (tcyc[i] - tcyc[i-1] != W + 2)
          $display("FAIL b2b spacing%0d: got %0d want %0d", i, tcyc[i] - tcyc[i-1], W + 2);
        else n_pass++;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    test_reset();
    test_basic(8'h5A, 8'h3C, 1'b0, 1'b0, "add_5a_3c");
    test_basic(8'hFF, 8'h01, 1'b0, 1'b0, "add_ff_01");
    test_basic(8'h00, 8'h00, 1'b1, 1'b0, "add_cin");
    test_basic(8'h10, 8'h01, 1'b1, 1'b1, "sub_10_01");
    test_basic(8'h01, 8'h02, 1'b0, 1'b1, "sub_borrow");
    test_basic(8'h80, 8'h01, 1'b0, 1'b1, "sub_ovf");
    test_ignore_start();
    test_reset_mid_op();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_serial_adder_ctrl
`default_nettype wire
